// File: rtl/y86_bus_arbiter_if.sv
// y86_bus_arbiter_if
// Groups the signals of both requesters and the memory bus for
// y86_bus_arbiter.
//   requester side : m0_*/m1_* req, we, addr, wdata in; gnt, done, err out;
//                    shared rdata out
//   memory side    : bus_A, bus_out, bus_WE, bus_RE out; bus_in, bus_ready in
// Modport slave is the arbiter's view; modport master is the view of
// whatever drives the requesters and models the memory.
interface y86_bus_arbiter_if;
   logic        m0_req;
   logic        m0_we;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m1_req;
   logic        m1_we;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m0_gnt;
   logic        m1_gnt;
   logic        m0_done;
   logic        m1_done;
   logic        m0_err;
   logic        m1_err;
   logic [31:0] rdata;
   logic [31:0] bus_A;
   logic [31:0] bus_out;
   logic        bus_WE;
   logic        bus_RE;
   logic [31:0] bus_in;
   logic        bus_ready;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  bus_in, bus_ready,
      output m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, rdata,
      output bus_A, bus_out, bus_WE, bus_RE
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output bus_in, bus_ready,
      input  m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, rdata,
      input  bus_A, bus_out, bus_WE, bus_RE
   );
endinterface

// File: rtl/y86_bus_arbiter.sv
// y86_bus_arbiter
// Two-requester round-robin arbiter in front of a single memory bus with a
// ready handshake and an access timeout.
//   clk : clock, all state changes on posedge
//   rst : synchronous active-low reset
//   io  : y86_bus_arbiter_if.slave (requester handshakes + memory bus)
// Parameter TIMEOUT (1..255): ACCESS cycles without bus_ready before the
// transaction is aborted with err.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no owner; arbitrate among pending requests
// ACCESS | owner drives the bus with latched request, waits for bus_ready
// RESP   | one-cycle done/err pulse to owner; pointer updated
module y86_bus_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input logic               clk,
   input logic               rst,
   y86_bus_arbiter_if.slave  io
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   // Terminal count: the TIMEOUT-th ACCESS cycle without ready aborts.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state;
   logic        last_srv;
   logic        owner;
   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [7:0]  wait_cnt;
   logic [31:0] rdata_r;
   logic        resp_err;

   logic        any_req;
   logic        winner;
   logic        in_access;
   logic        in_resp;

   assign any_req = io.m0_req | io.m1_req;
   // On a tie the requester not served last wins; otherwise the lone one.
   assign winner  = (io.m0_req & io.m1_req) ? ~last_srv : io.m1_req;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         last_srv  <= 1'b1;
         owner     <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         wait_cnt  <= 8'd0;
         rdata_r   <= 32'd0;
         resp_err  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  owner     <= winner;
                  lat_we    <= winner ? io.m1_we    : io.m0_we;
                  lat_addr  <= winner ? io.m1_addr  : io.m0_addr;
                  lat_wdata <= winner ? io.m1_wdata : io.m0_wdata;
                  wait_cnt  <= 8'd0;
                  state     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               // bus_ready wins over an expiring timeout in the same cycle.
               if (io.bus_ready) begin
                  if (!lat_we) begin
                     rdata_r <= io.bus_in;
                  end
                  resp_err <= 1'b0;
                  state    <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  if (wait_cnt == WAIT_LAST) begin
                     resp_err <= 1'b1;
                     state    <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               last_srv <= owner;
               state    <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_access = (state == ST_ACCESS);
   assign in_resp   = (state == ST_RESP);

   assign io.m0_gnt  = in_access & ~owner;
   assign io.m1_gnt  = in_access &  owner;
   assign io.m0_done = in_resp & ~resp_err & ~owner;
   assign io.m1_done = in_resp & ~resp_err &  owner;
   assign io.m0_err  = in_resp &  resp_err & ~owner;
   assign io.m1_err  = in_resp &  resp_err &  owner;
   assign io.rdata   = rdata_r;

   assign io.bus_A   = in_access ? lat_addr  : 32'd0;
   assign io.bus_out = in_access ? lat_wdata : 32'd0;
   assign io.bus_WE  = in_access &  lat_we;
   assign io.bus_RE  = in_access & ~lat_we;

endmodule
